// File: rtl/lsu_ctrl.sv
// Load/store unit controller: sits between the ALU and data memory.
// Generates byte enables and lane-replicated store data, sign/zero-extends
// load data, and runs a req/ack handshake with an optional BUSY timeout.
// Optional feature: define LSU_MISALIGN_TRAP_EN to trap misaligned or
// undefined-size accesses instead of force-aligning them.
module lsu_ctrl #(
    parameter int MEM_AW      = 14,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_lsu_valid,
    input  logic              i_lsu_wren,
    input  logic [31:0]       i_lsu_addr,
    input  logic [31:0]       i_st_data,
    input  logic [2:0]        i_funct3,
    output logic              o_stall,
    output logic              o_done,
    output logic              o_err,
    output logic [31:0]       o_ld_data,
    output logic              o_mem_req,
    output logic              o_mem_we,
    output logic [MEM_AW-1:0] o_mem_addr,
    output logic [3:0]        o_mem_be,
    output logic [31:0]       o_mem_wdata,
    input  logic              i_mem_ack,
    input  logic [31:0]       i_mem_rdata
);

    // Counter only needs to reach TIMEOUT_CYC-1: expiry is the last BUSY cycle.
    localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST =
        (TIMEOUT_CYC > 0) ? CNT_W'(TIMEOUT_CYC - 1) : '0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              start, fin_ok, fin_err;

    logic              we_q;
    logic [MEM_AW-1:0] addr_q;
    logic [3:0]        be_q;
    logic [31:0]       wdata_q;
    logic [2:0]        f3_q;
    logic [1:0]        lane_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              err_q;
    logic [31:0]       ld_q;

    logic              is_b, is_h, bad_d;
    logic [1:0]        lane_d;
    logic [3:0]        be_d;
    logic [31:0]       wdata_d;
    logic [31:0]       rd_sh, ld_ext;

    // Upper address bits lie outside the memory window.
    logic unused_addr;
    assign unused_addr = &{1'b0, i_lsu_addr[31:MEM_AW+2]};

    // Request decode: aligned lane, byte enables, replicated store data, trap check.
    always_comb begin
        is_b    = (i_funct3[1:0] == 2'b00);
        is_h    = (i_funct3[1:0] == 2'b01);
        bad_d   = 1'b0;
        lane_d  = 2'b00;
        be_d    = 4'b1111;
        wdata_d = i_st_data;
        if (is_b) begin
            lane_d  = i_lsu_addr[1:0];
            be_d    = 4'b0001 << lane_d;
            wdata_d = {4{i_st_data[7:0]}};
        end else if (is_h) begin
            lane_d  = {i_lsu_addr[1], 1'b0};
            be_d    = 4'b0011 << lane_d;
            wdata_d = {2{i_st_data[15:0]}};
        end
`ifdef LSU_MISALIGN_TRAP_EN
        bad_d = (i_funct3 == 3'b011) || (i_funct3[2:1] == 2'b11) ||
                (is_h && i_lsu_addr[0]) ||
                (!is_b && !is_h && (i_lsu_addr[1:0] != 2'b00));
`endif
    end

    // Load alignment and extension from the latched lane and size.
    always_comb begin
        rd_sh = i_mem_rdata >> {lane_q, 3'b000};
        case (f3_q[1:0])
            2'b00:   ld_ext = f3_q[2] ? {24'h0, rd_sh[7:0]}
                                      : {{24{rd_sh[7]}}, rd_sh[7:0]};
            2'b01:   ld_ext = f3_q[2] ? {16'h0, rd_sh[15:0]}
                                      : {{16{rd_sh[15]}}, rd_sh[15:0]};
            default: ld_ext = rd_sh;
        endcase
    end

    // Next-state logic; ack takes priority over timeout expiry in the same cycle.
    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        fin_ok  = 1'b0;
        fin_err = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_lsu_valid) begin
                    if (bad_d) begin
                        state_d = ST_DONE;
                        fin_err = 1'b1;
                    end else begin
                        state_d = ST_BUSY;
                        start   = 1'b1;
                    end
                end
            end
            ST_BUSY: begin
                if (i_mem_ack) begin
                    state_d = ST_DONE;
                    fin_ok  = 1'b1;
                end else if ((TIMEOUT_CYC > 0) && (cnt_q == CNT_LAST)) begin
                    state_d = ST_DONE;
                    fin_err = 1'b1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    // Request latch, timeout counter, and completion results.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            we_q    <= 1'b0;
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            f3_q    <= '0;
            lane_q  <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            ld_q    <= '0;
        end else begin
            if (start) begin
                we_q    <= i_lsu_wren;
                addr_q  <= i_lsu_addr[MEM_AW+1:2];
                be_q    <= be_d;
                wdata_q <= wdata_d;
                f3_q    <= i_funct3;
                lane_q  <= lane_d;
                cnt_q   <= '0;
            end else if ((state_q == ST_BUSY) && (TIMEOUT_CYC > 0)) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
            if (fin_ok) begin
                err_q <= 1'b0;
                if (!we_q) ld_q <= ld_ext;
            end
            if (fin_err) begin
                err_q <= 1'b1;
                ld_q  <= '0;
            end
        end
    end

    assign o_done      = (state_q == ST_DONE);
    assign o_mem_req   = (state_q == ST_BUSY);
    assign o_stall     = i_lsu_valid & ~o_done;
    assign o_err       = err_q;
    assign o_ld_data   = ld_q;
    assign o_mem_we    = we_q;
    assign o_mem_addr  = addr_q;
    assign o_mem_be    = be_q;
    assign o_mem_wdata = wdata_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Self-checking bench for lsu_ctrl: vector table plus scoreboard queue,
// with a hand-written async-reset-during-BUSY sequence.
module tb_lsu_ctrl;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_lsu_valid, i_lsu_wren;
    logic [31:0] i_lsu_addr, i_st_data;
    logic [2:0]  i_funct3;
    logic        o_stall, o_done, o_err;
    logic [31:0] o_ld_data;
    logic        o_mem_req, o_mem_we;
    logic [13:0] o_mem_addr;
    logic [3:0]  o_mem_be;
    logic [31:0] o_mem_wdata;
    logic        i_mem_ack;
    logic [31:0] i_mem_rdata;

    int total = 0;
    int bad   = 0;

    always #5 i_clk = ~i_clk;

    lsu_ctrl #(.MEM_AW(14), .TIMEOUT_CYC(255)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_lsu_valid(i_lsu_valid), .i_lsu_wren(i_lsu_wren),
        .i_lsu_addr(i_lsu_addr), .i_st_data(i_st_data), .i_funct3(i_funct3),
        .o_stall(o_stall), .o_done(o_done), .o_err(o_err), .o_ld_data(o_ld_data),
        .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
        .o_mem_be(o_mem_be), .o_mem_wdata(o_mem_wdata),
        .i_mem_ack(i_mem_ack), .i_mem_rdata(i_mem_rdata)
    );

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] sdata;
        logic [2:0]  f3;
        int          ack_at;     // req cycle in which ack is given, 0 = never
        logic [31:0] rdata;
        logic        flush;      // drop valid once BUSY
        int          exp_reqs;
        logic [31:0] exp_maddr;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
        logic [31:0] exp_ld;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    typedef struct {
        logic [31:0] ld;
        logic        err;
        int          lat;
        int          reqs;
    } exp_t;

    vec_t vecs[$];
    exp_t sb_q[$];

    function automatic vec_t mk(logic we, logic [31:0] addr, logic [31:0] sdata,
                                logic [2:0] f3, int ack_at, logic [31:0] rdata,
                                logic flush, int exp_reqs, logic [31:0] exp_maddr,
                                logic [3:0] exp_be, logic [31:0] exp_wdata,
                                logic [31:0] exp_ld, logic exp_err, int exp_lat);
        vec_t v;
        v.we = we; v.addr = addr; v.sdata = sdata; v.f3 = f3;
        v.ack_at = ack_at; v.rdata = rdata; v.flush = flush;
        v.exp_reqs = exp_reqs; v.exp_maddr = exp_maddr; v.exp_be = exp_be;
        v.exp_wdata = exp_wdata; v.exp_ld = exp_ld; v.exp_err = exp_err;
        v.exp_lat = exp_lat;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Drive one access from an IDLE cycle, serve the memory side, check on o_done.
    task automatic run_vec(input int idx, input vec_t v);
        int   cyc;
        int   reqs;
        bit   seen;
        exp_t e;
        @(posedge i_clk); #1;
        i_lsu_valid = 1'b1;
        i_lsu_wren  = v.we;
        i_lsu_addr  = v.addr;
        i_st_data   = v.sdata;
        i_funct3    = v.f3;
        i_mem_ack   = 1'b0;
        sb_q.push_back('{ld: v.exp_ld, err: v.exp_err, lat: v.exp_lat, reqs: v.exp_reqs});
        cyc = 0; reqs = 0; seen = 0;
        while (!seen && cyc < 400) begin
            @(posedge i_clk); #1;
            cyc++;
            i_mem_ack   = 1'b0;
            i_mem_rdata = 32'hBAD0_BAD0;
            if (cyc == 1 && v.exp_lat > 1)
                chk($sformatf("v%0d_stall_busy", idx), {31'b0, o_stall}, 32'd1);
            if (v.flush && cyc == 1) i_lsu_valid = 1'b0;
            if (o_mem_req) begin
                reqs++;
                if (reqs == 1) begin
                    chk($sformatf("v%0d_maddr", idx), {18'b0, o_mem_addr}, v.exp_maddr);
                    chk($sformatf("v%0d_be", idx), {28'b0, o_mem_be}, {28'b0, v.exp_be});
                    chk($sformatf("v%0d_we", idx), {31'b0, o_mem_we}, {31'b0, v.we});
                    if (v.we)
                        chk($sformatf("v%0d_wdata", idx), o_mem_wdata, v.exp_wdata);
                end
                if (v.ack_at != 0 && reqs == v.ack_at) begin
                    i_mem_ack   = 1'b1;
                    i_mem_rdata = v.rdata;
                end
            end
            if (o_done) begin
                seen = 1;
                if (sb_q.size() == 0) begin
                    chk($sformatf("v%0d_sb_empty", idx), 32'd0, 32'd1);
                end else begin
                    e = sb_q.pop_front();
                    chk($sformatf("v%0d_ld", idx), o_ld_data, e.ld);
                    chk($sformatf("v%0d_err", idx), {31'b0, o_err}, {31'b0, e.err});
                    chk($sformatf("v%0d_lat", idx), cyc, e.lat);
                    chk($sformatf("v%0d_reqs", idx), reqs, e.reqs);
                end
                chk($sformatf("v%0d_stall_done", idx), {31'b0, o_stall}, 32'd0);
            end
        end
        if (!seen) chk($sformatf("v%0d_done_timeout", idx), 32'd0, 32'd1);
        i_lsu_valid = 1'b0;
        i_mem_ack   = 1'b0;
    endtask

    initial begin
        int viol;
        i_rst_n = 1'b0; i_lsu_valid = 1'b0; i_lsu_wren = 1'b0; i_lsu_addr = '0;
        i_st_data = '0; i_funct3 = '0; i_mem_ack = 1'b0; i_mem_rdata = '0;

        //      we  addr          sdata         f3      ack  rdata         fl reqs maddr    be       wdata         ld            err lat
        vecs.push_back(mk(1, 32'h100,      32'hDEADBEEF, 3'b010, 1,   32'h0,        0, 1,   32'h40,  4'b1111, 32'hDEADBEEF, 32'h0,        0, 2));
        vecs.push_back(mk(1, 32'h103,      32'h000000A5, 3'b000, 2,   32'h0,        0, 2,   32'h40,  4'b1000, 32'hA5A5A5A5, 32'h0,        0, 3));
        vecs.push_back(mk(1, 32'h102,      32'h1234ABCD, 3'b001, 1,   32'h0,        0, 1,   32'h40,  4'b1100, 32'hABCDABCD, 32'h0,        0, 2));
        vecs.push_back(mk(0, 32'h102,      32'h0,        3'b000, 3,   32'h12F45678, 0, 3,   32'h40,  4'b0100, 32'h0,        32'hFFFFFFF4, 0, 4));
        vecs.push_back(mk(0, 32'h102,      32'h0,        3'b100, 3,   32'h12F45678, 0, 3,   32'h40,  4'b0100, 32'h0,        32'h000000F4, 0, 4));
        vecs.push_back(mk(0, 32'h102,      32'h0,        3'b001, 3,   32'h12F45678, 0, 3,   32'h40,  4'b1100, 32'h0,        32'h000012F4, 0, 4));
        vecs.push_back(mk(0, 32'h200,      32'h0,        3'b101, 1,   32'h00008001, 0, 1,   32'h80,  4'b0011, 32'h0,        32'h00008001, 0, 2));
        vecs.push_back(mk(0, 32'h200,      32'h0,        3'b001, 1,   32'h00008001, 0, 1,   32'h80,  4'b0011, 32'h0,        32'hFFFF8001, 0, 2));
        vecs.push_back(mk(0, 32'h001,      32'h0,        3'b000, 2,   32'h00008000, 0, 2,   32'h0,   4'b0010, 32'h0,        32'hFFFFFF80, 0, 3));
        vecs.push_back(mk(0, 32'h3FFC,     32'h0,        3'b010, 2,   32'hCAFEBABE, 0, 2,   32'hFFF, 4'b1111, 32'h0,        32'hCAFEBABE, 0, 3));
        vecs.push_back(mk(1, 32'h4,        32'h01020304, 3'b010, 1,   32'h0,        0, 1,   32'h1,   4'b1111, 32'h01020304, 32'hCAFEBABE, 0, 2));
        vecs.push_back(mk(0, 32'hFFFF0008, 32'h0,        3'b010, 3,   32'h76543210, 1, 3,   32'h2,   4'b1111, 32'h0,        32'h76543210, 0, 4));
        vecs.push_back(mk(0, 32'h20,       32'h0,        3'b010, 0,   32'h0,        0, 255, 32'h8,   4'b1111, 32'h0,        32'h0,        1, 256));
        vecs.push_back(mk(1, 32'h21,       32'h0000007E, 3'b000, 1,   32'h0,        0, 1,   32'h8,   4'b0010, 32'h7E7E7E7E, 32'h0,        0, 2));
        vecs.push_back(mk(0, 32'h20,       32'h0,        3'b010, 255, 32'h5A5A0F0F, 0, 255, 32'h8,   4'b1111, 32'h0,        32'h5A5A0F0F, 0, 256));
`ifdef LSU_MISALIGN_TRAP_EN
        vecs.push_back(mk(0, 32'h101,      32'h0,        3'b010, 1,   32'h11223344, 0, 0,   32'h0,   4'b0000, 32'h0,        32'h0,        1, 1));
        vecs.push_back(mk(0, 32'h106,      32'h0,        3'b111, 1,   32'h99887766, 0, 0,   32'h0,   4'b0000, 32'h0,        32'h0,        1, 1));
        vecs.push_back(mk(0, 32'h103,      32'h0,        3'b101, 1,   32'hABCD1234, 0, 0,   32'h0,   4'b0000, 32'h0,        32'h0,        1, 1));
`else
        vecs.push_back(mk(0, 32'h101,      32'h0,        3'b010, 1,   32'h11223344, 0, 1,   32'h40,  4'b1111, 32'h0,        32'h11223344, 0, 2));
        vecs.push_back(mk(0, 32'h106,      32'h0,        3'b111, 1,   32'h99887766, 0, 1,   32'h41,  4'b1111, 32'h0,        32'h99887766, 0, 2));
        vecs.push_back(mk(0, 32'h103,      32'h0,        3'b101, 1,   32'hABCD1234, 0, 1,   32'h40,  4'b1100, 32'h0,        32'h0000ABCD, 0, 2));
`endif

        // Reset state
        #1;
        chk("rst_req",   {31'b0, o_mem_req}, 32'd0);
        chk("rst_done",  {31'b0, o_done}, 32'd0);
        chk("rst_err",   {31'b0, o_err}, 32'd0);
        chk("rst_ld",    o_ld_data, 32'd0);
        chk("rst_stall", {31'b0, o_stall}, 32'd0);
        chk("rst_be",    {28'b0, o_mem_be}, 32'd0);
        chk("rst_maddr", {18'b0, o_mem_addr}, 32'd0);
        repeat (2) @(posedge i_clk);
        @(negedge i_clk) i_rst_n = 1'b1;

        foreach (vecs[i]) run_vec(i, vecs[i]);

        // Async reset while BUSY: req drops at once, late ack ignored, no done.
        @(posedge i_clk); #1;
        i_lsu_valid = 1'b1; i_lsu_wren = 1'b0; i_lsu_addr = 32'h40; i_funct3 = 3'b010;
        @(posedge i_clk); #1;
        chk("arst_req_busy", {31'b0, o_mem_req}, 32'd1);
        @(posedge i_clk); #2;
        i_rst_n = 1'b0;
        #1;
        chk("arst_req_drop", {31'b0, o_mem_req}, 32'd0);
        chk("arst_done",     {31'b0, o_done}, 32'd0);
        chk("arst_ld",       o_ld_data, 32'd0);
        i_lsu_valid = 1'b0;
        @(negedge i_clk) i_rst_n = 1'b1;
        @(posedge i_clk); #1;
        i_mem_ack = 1'b1; i_mem_rdata = 32'h13572468;
        viol = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge i_clk); #1;
            i_mem_ack = 1'b0;
            if (o_done || o_mem_req) viol++;
        end
        chk("arst_late_ack", viol, 32'd0);
        chk("arst_ld_hold", o_ld_data, 32'd0);
        chk("sb_drained", sb_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
